// File: rtl/reg_bank_write_port.sv
// Write side and storage of the 16-entry register bank, with a sequenced clear and sticky select-error flag.
// Optional macro REG_ZERO_HARDWIRE_EN turns r0 into a constant zero that ignores writes and clears.
module reg_bank_write_port #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [4:0]       wr_select,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear_req,
  output logic             busy,
  output logic             err_sel,
  input  logic             err_clr,
  output logic [7:0]       write_count,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regs [16];
  logic [3:0]       r_clearIdx;
  logic             r_busy;
  logic             r_errSel;
  logic [7:0]       r_writeCount;

  logic       w_accept;
  logic       w_selInvalid;
  logic       w_selWrites;
  logic [3:0] w_target;

  assign wr_ready     = (r_state == IDLE) && !clear_req;
  assign w_accept     = wr_valid && wr_ready;
  assign w_selInvalid = (wr_select > 5'd16);
  assign w_target     = 4'(wr_select - 5'd1);

  // Select is one-based: 0 means "no register", so only 1..16 commit data.
`ifdef REG_ZERO_HARDWIRE_EN
  assign w_selWrites = (wr_select >= 5'd2) && !w_selInvalid;
`else
  assign w_selWrites = (wr_select != 5'd0) && !w_selInvalid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_errSel     <= 1'b0;
      r_writeCount <= '0;
      r_clearIdx   <= '0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req) begin
            r_state    <= CLEAR;
            r_busy     <= 1'b1;
            r_clearIdx <= '0;
          end else if (w_accept && w_selWrites) begin
            r_regs[w_target] <= wr_data;
            r_writeCount     <= r_writeCount + 8'd1;
          end
        end
        CLEAR: begin
          r_regs[r_clearIdx] <= CLEAR_VALUE;
          r_clearIdx         <= r_clearIdx + 4'd1;
          if (r_clearIdx == 4'd15) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase

      // A new error in the same cycle as err_clr must not be lost.
      if (w_accept && w_selInvalid) r_errSel <= 1'b1;
      else if (err_clr)             r_errSel <= 1'b0;

`ifdef REG_ZERO_HARDWIRE_EN
      r_regs[0] <= '0;
`endif
    end
  end

  assign busy        = r_busy;
  assign err_sel     = r_errSel;
  assign write_count = r_writeCount;

  assign r0  = r_regs[0];
  assign r1  = r_regs[1];
  assign r2  = r_regs[2];
  assign r3  = r_regs[3];
  assign r4  = r_regs[4];
  assign r5  = r_regs[5];
  assign r6  = r_regs[6];
  assign r7  = r_regs[7];
  assign r8  = r_regs[8];
  assign r9  = r_regs[9];
  assign r10 = r_regs[10];
  assign r11 = r_regs[11];
  assign r12 = r_regs[12];
  assign r13 = r_regs[13];
  assign r14 = r_regs[14];
  assign r15 = r_regs[15];

endmodule

// File: tb/tb_reg_bank_write_port.sv
// Scoreboard bench for reg_bank_write_port: a cycle-level model queues expectations, a monitor checks them.
// Honours REG_ZERO_HARDWIRE_EN the same way the design does.
module tb_reg_bank_write_port;

  localparam logic [15:0] CV = 16'h00AA;

  typedef struct packed {
    logic              ready;
    logic              busy;
    logic              err;
    logic [7:0]        cnt;
    logic [15:0][15:0] regs;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [4:0]  wr_select = '0;
  logic [15:0] wr_data = '0;
  logic        clear_req = 1'b0;
  logic        busy;
  logic        err_sel;
  logic        err_clr = 1'b0;
  logic [7:0]  write_count;
  logic [15:0] dutR [16];

  int totalChecks = 0;
  int badChecks   = 0;

  exp_t expQ[$];

  // Behavioural model: plain array of register values plus bookkeeping.
  logic [15:0] mRegs [16];
  int          mCount    = 0;
  bit          mErr      = 1'b0;
  int          mClearPos = -1;

  reg_bank_write_port #(.WIDTH(16), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_select(wr_select), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy),
    .err_sel(err_sel), .err_clr(err_clr),
    .write_count(write_count),
    .r0(dutR[0]),   .r1(dutR[1]),   .r2(dutR[2]),   .r3(dutR[3]),
    .r4(dutR[4]),   .r5(dutR[5]),   .r6(dutR[6]),   .r7(dutR[7]),
    .r8(dutR[8]),   .r9(dutR[9]),   .r10(dutR[10]), .r11(dutR[11]),
    .r12(dutR[12]), .r13(dutR[13]), .r14(dutR[14]), .r15(dutR[15])
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] want);
    totalChecks++;
    if (got !== want) begin
      badChecks++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue what the bank should show after the next rising edge.
  task automatic applyStimulus(input bit v, input logic [4:0] sel, input logic [15:0] d,
                               input bit clr, input bit ec, input bit rs);
    exp_t e;
    bit   setErr;
    @(negedge clk);
    wr_valid  = v;
    wr_select = sel;
    wr_data   = d;
    clear_req = clr;
    err_clr   = ec;
    reset     = rs;
    setErr    = 1'b0;
    if (rs) begin
      for (int i = 0; i < 16; i++) mRegs[i] = '0;
      mCount    = 0;
      mErr      = 1'b0;
      mClearPos = -1;
      e.ready   = !clr;
    end else begin
      e.ready = (mClearPos < 0) && !clr;
      if (mClearPos >= 0) begin
        mRegs[mClearPos] = CV;
        mClearPos++;
        if (mClearPos == 16) mClearPos = -1;
      end else if (clr) begin
        mClearPos = 0;
      end else if (v) begin
        if (sel >= 5'd17) setErr = 1'b1;
`ifdef REG_ZERO_HARDWIRE_EN
        else if (sel >= 5'd2) begin
`else
        else if (sel >= 5'd1) begin
`endif
          mRegs[int'(sel) - 1] = d;
          mCount = (mCount + 1) % 256;
        end
      end
      if (setErr)  mErr = 1'b1;
      else if (ec) mErr = 1'b0;
    end
`ifdef REG_ZERO_HARDWIRE_EN
    mRegs[0] = '0;
`endif
    e.busy = (mClearPos >= 0);
    e.err  = mErr;
    e.cnt  = 8'(mCount);
    for (int i = 0; i < 16; i++) e.regs[i] = mRegs[i];
    expQ.push_back(e);
  endtask

  // Monitor: wr_ready is checked mid-cycle, registered outputs just after the rising edge.
  initial begin : monitor
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() != 0) begin
        cur = expQ.pop_front();
        checkOutput("wr_ready", {15'd0, wr_ready}, {15'd0, cur.ready});
        @(posedge clk);
        #1;
        checkOutput("busy", {15'd0, busy}, {15'd0, cur.busy});
        checkOutput("err_sel", {15'd0, err_sel}, {15'd0, cur.err});
        checkOutput("write_count", {8'd0, write_count}, {8'd0, cur.cnt});
        for (int i = 0; i < 16; i++)
          checkOutput($sformatf("r%0d", i), dutR[i], cur.regs[i]);
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 16; i++) mRegs[i] = '0;

    applyStimulus(0, 5'd0, 16'h0, 0, 0, 1);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 1);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);

    // Single write lands in r4.
    applyStimulus(1, 5'd5, 16'hBEEF, 0, 0, 0);
    applyStimulus(0, 5'd5, 16'h0, 0, 0, 0);

    for (int i = 0; i < 16; i++) applyStimulus(1, 5'(i + 1), 16'h1000 + 16'(i), 0, 0, 0);

    // Clear pulse with a write held pending throughout.
    applyStimulus(1, 5'd3, 16'h5555, 1, 0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(1, 5'd3, 16'h5555, 0, 0, 0);
    applyStimulus(1, 5'd3, 16'h5555, 0, 0, 0);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);

    // Invalid selects and sticky error behaviour.
    applyStimulus(1, 5'd20, 16'h1234, 0, 0, 0);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);
    applyStimulus(1, 5'd31, 16'h4321, 0, 1, 0);
    applyStimulus(0, 5'd0, 16'h0, 0, 1, 0);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);

    // Select 0 is a no-op; 256 writes to r15 wrap the counter.
    applyStimulus(1, 5'd0, 16'hDEAD, 0, 0, 0);
    for (int i = 0; i < 256; i++) applyStimulus(1, 5'd16, 16'($urandom), 0, 0, 0);

    // Register r0 write (hardwired-zero case when the macro is defined).
    applyStimulus(1, 5'd1, 16'hFFFF, 0, 0, 0);

    // Reset landing on the 6th clear cycle.
    applyStimulus(0, 5'd0, 16'h0, 1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 1);
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);
    applyStimulus(1, 5'd9, 16'hA5A5, 0, 0, 0);

    // Randomised traffic including occasional clears, error clears and resets.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 16'($urandom),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 79) == 0));
    end
    applyStimulus(0, 5'd0, 16'h0, 0, 0, 0);

    repeat (2) @(negedge clk);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
